// File: rtl/rowram_scheduler.sv
// Row RAM render scheduler: paces PPU row renders against display buffer swaps,
// frames the visible rows of each frame and tracks render underruns.
module rowram_scheduler #(
    parameter int VISIBLE_ROWS = 240,
    parameter int ROW_W        = 8,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_start,
    input  logic             rowram_swap,
    input  logic             render_done,
    input  logic             stat_clr,
    output logic             render_start,
    output logic             render_abort,
    output logic [ROW_W-1:0] render_row,
    output logic             render_buf,
    output logic             disp_buf,
    output logic             vblank_start,
    output logic             busy,
    output logic             underrun,
    output logic [CNT_W-1:0] underrun_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        READY = 2'd2
    } state_t;

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(VISIBLE_ROWS - 1);

    state_t           state, state_n;
    logic [ROW_W-1:0] row_n;
    logic             rbuf_n;
    logic             start_n;
    logic             abort_n;
    logic             vblank_n;
    logic             ur_hit;
    logic             do_swap;
    logic             last_row;

    assign last_row = (render_row == LAST_ROW);

    // Next-state and next-output decode; frame_start overrides everything else.
    always_comb begin
        state_n  = state;
        row_n    = render_row;
        rbuf_n   = render_buf;
        start_n  = 1'b0;
        abort_n  = 1'b0;
        vblank_n = 1'b0;
        ur_hit   = 1'b0;
        do_swap  = 1'b0;

        if (frame_start) begin
            // Resync: restart at row 0, drop any in-flight render, keep buffers.
            row_n   = '0;
            start_n = 1'b1;
            abort_n = (state == BUSY);
            state_n = BUSY;
        end else begin
            case (state)
                IDLE: ;
                BUSY: begin
                    if (render_done && rowram_swap) begin
                        // Done and swap together behave as done-then-swap.
                        do_swap = 1'b1;
                    end else if (render_done) begin
                        state_n = READY;
                    end else if (rowram_swap) begin
                        // Underrun: display repeats the stale buffer, the PPU
                        // abandons this row and moves to the next one in place.
                        ur_hit  = 1'b1;
                        abort_n = 1'b1;
                        if (last_row) begin
                            vblank_n = 1'b1;
                            state_n  = IDLE;
                        end else begin
                            row_n   = render_row + 1'b1;
                            start_n = 1'b1;
                        end
                    end
                end
                READY: begin
                    if (rowram_swap) do_swap = 1'b1;
                end
                default: state_n = IDLE;
            endcase

            if (do_swap) begin
                rbuf_n = ~render_buf;
                if (last_row) begin
                    vblank_n = 1'b1;
                    state_n  = IDLE;
                end else begin
                    row_n   = render_row + 1'b1;
                    start_n = 1'b1;
                    state_n = BUSY;
                end
            end
        end
    end

    // State and registered outputs; disp_buf always mirrors ~render_buf.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            render_row   <= '0;
            render_buf   <= 1'b0;
            disp_buf     <= 1'b1;
            render_start <= 1'b0;
            render_abort <= 1'b0;
            vblank_start <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_n;
            render_row   <= row_n;
            render_buf   <= rbuf_n;
            disp_buf     <= ~rbuf_n;
            render_start <= start_n;
            render_abort <= abort_n;
            vblank_start <= vblank_n;
            busy         <= (state_n == BUSY);
        end
    end

    // Underrun statistics; an underrun in the clearing cycle survives the clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            underrun     <= 1'b0;
            underrun_cnt <= '0;
        end else if (stat_clr) begin
            underrun     <= ur_hit;
            underrun_cnt <= ur_hit ? CNT_W'(1) : '0;
        end else if (ur_hit) begin
            underrun <= 1'b1;
            if (underrun_cnt != '1) underrun_cnt <= underrun_cnt + 1'b1;
        end
    end

endmodule
